// File: rtl/rv32i_defs.sv
// Shared RV32I core definitions: datapath/register widths and the ID/EX control bundle.
package rv32i_defs;

    localparam int XLEN          = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH  = 4;

    // Control bits carried from ID into EX; a bubble clears the whole bundle at once.
    typedef struct packed {
        logic                    regWrite;
        logic                    memRead;
        logic                    memWrite;
        logic                    memToReg;
        logic                    branch;
        logic [ALU_OP_WIDTH-1:0] aluOp;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_CTRL_NOP = '0;

endpackage

// File: rtl/idex_stage_haz_detect.sv
// Load-use hazard detector: flags an ID instruction that needs a load result still in EX.
module haz_detect
    import rv32i_defs::*;
(
    input  logic                     idValid,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic                     idMemWrite,
    input  logic                     idexValid,
    input  logic                     idexMemRead,
    input  logic [RF_ADDR_WIDTH-1:0] idexRd,
    output logic                     loadUse
);

    logic loadInEx;
    logic rs1Dep;
    logic rs2Dep;

    // A store's data operand (rs2) is forwarded at MEM, so it never needs a bubble.
    always_comb begin
        loadInEx = idValid & idexValid & idexMemRead & (idexRd != '0);
        rs1Dep   = idUsesRs1 & (idRs1 == idexRd);
        rs2Dep   = idUsesRs2 & (idRs2 == idexRd) & ~idMemWrite;
        loadUse  = loadInEx & (rs1Dep | rs2Dep);
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold,
// same-cycle WB bypass into the captured operands and a saturating bubble counter.
module idex_stage
    import rv32i_defs::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idValid,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idRd,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic                     idRegWrite,
    input  logic                     idMemRead,
    input  logic                     idMemWrite,
    input  logic                     idMemToReg,
    input  logic                     idBranch,
    input  logic [ALU_OP_WIDTH-1:0]  idAluOp,
    input  logic [XLEN-1:0]          idRdata1,
    input  logic [XLEN-1:0]          idRdata2,
    input  logic [XLEN-1:0]          idImm,
    input  logic [XLEN-1:0]          idPc,
    input  logic                     wbRegWrite,
    input  logic [RF_ADDR_WIDTH-1:0] wbRd,
    input  logic [XLEN-1:0]          wbData,
    input  logic                     exFlush,
    input  logic                     exStall,
    output logic                     idexValid,
    output logic [RF_ADDR_WIDTH-1:0] idexRs1,
    output logic [RF_ADDR_WIDTH-1:0] idexRs2,
    output logic [RF_ADDR_WIDTH-1:0] idexRd,
    output logic                     idexRegWrite,
    output logic                     idexMemRead,
    output logic                     idexMemWrite,
    output logic                     idexMemToReg,
    output logic                     idexBranch,
    output logic [ALU_OP_WIDTH-1:0]  idexAluOp,
    output logic [XLEN-1:0]          idexRdata1,
    output logic [XLEN-1:0]          idexRdata2,
    output logic [XLEN-1:0]          idexImm,
    output logic [XLEN-1:0]          idexPc,
    output logic                     idStall,
    output logic [CNT_WIDTH-1:0]     bubbleCnt
);

    logic                     validQ;
    logic [RF_ADDR_WIDTH-1:0] rs1Q, rs2Q, rdQ;
    idex_ctrl_t               ctrlQ;
    idex_ctrl_t               idCtrl;
    logic [XLEN-1:0]          rdata1Q, rdata2Q, immQ, pcQ;
    logic [CNT_WIDTH-1:0]     cntQ;
    logic                     loadUse;
    logic                     byp1, byp2;
    logic [XLEN-1:0]          opA, opB;

    haz_detect uHaz (
        .idValid     (idValid),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .idMemWrite  (idMemWrite),
        .idexValid   (validQ),
        .idexMemRead (ctrlQ.memRead),
        .idexRd      (rdQ),
        .loadUse     (loadUse)
    );

    // Pack decoded control and apply the WB bypass to the operands being captured.
    always_comb begin
        idCtrl.regWrite = idRegWrite;
        idCtrl.memRead  = idMemRead;
        idCtrl.memWrite = idMemWrite;
        idCtrl.memToReg = idMemToReg;
        idCtrl.branch   = idBranch;
        idCtrl.aluOp    = idAluOp;
        byp1            = wbRegWrite & (wbRd != '0) & (wbRd == idRs1);
        byp2            = wbRegWrite & (wbRd != '0) & (wbRd == idRs2);
        opA             = byp1 ? wbData : idRdata1;
        opB             = byp2 ? wbData : idRdata2;
        idStall         = (loadUse | exStall) & ~exFlush;
    end

    // Stage register: flush > hold > load-use bubble > capture (invalid ID captures as a bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ  <= 1'b0;
            rs1Q    <= '0;
            rs2Q    <= '0;
            rdQ     <= '0;
            ctrlQ   <= IDEX_CTRL_NOP;
            rdata1Q <= '0;
            rdata2Q <= '0;
            immQ    <= '0;
            pcQ     <= '0;
            cntQ    <= '0;
        end else if (exFlush || (!exStall && (loadUse || !idValid))) begin
            validQ  <= 1'b0;
            rs1Q    <= '0;
            rs2Q    <= '0;
            rdQ     <= '0;
            ctrlQ   <= IDEX_CTRL_NOP;
            rdata1Q <= '0;
            rdata2Q <= '0;
            immQ    <= '0;
            pcQ     <= '0;
            if (!exFlush && loadUse && (cntQ != '1))
                cntQ <= cntQ + CNT_WIDTH'(1);
        end else if (!exStall) begin
            validQ  <= 1'b1;
            rs1Q    <= idRs1;
            rs2Q    <= idRs2;
            rdQ     <= idRd;
            ctrlQ   <= idCtrl;
            rdata1Q <= opA;
            rdata2Q <= opB;
            immQ    <= idImm;
            pcQ     <= idPc;
        end
    end

    assign idexValid    = validQ;
    assign idexRs1      = rs1Q;
    assign idexRs2      = rs2Q;
    assign idexRd       = rdQ;
    assign idexRegWrite = ctrlQ.regWrite;
    assign idexMemRead  = ctrlQ.memRead;
    assign idexMemWrite = ctrlQ.memWrite;
    assign idexMemToReg = ctrlQ.memToReg;
    assign idexBranch   = ctrlQ.branch;
    assign idexAluOp    = ctrlQ.aluOp;
    assign idexRdata1   = rdata1Q;
    assign idexRdata2   = rdata2Q;
    assign idexImm      = immQ;
    assign idexPc       = pcQ;
    assign bubbleCnt    = cntQ;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed scenarios plus a randomized run
// against a behavioural model of the stage contents.
module tb_idex_stage;
    import rv32i_defs::*;

    localparam int CW = 2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        regWrite, memRead, memWrite, memToReg, branch;
        logic [3:0]  aluOp;
        logic [31:0] rdata1, rdata2, imm, pc;
        logic [CW-1:0] cnt;
    } st_t;

    logic clk, rst_n;
    logic idValid, idUsesRs1, idUsesRs2;
    logic [4:0] idRs1, idRs2, idRd, wbRd;
    logic idRegWrite, idMemRead, idMemWrite, idMemToReg, idBranch, wbRegWrite, exFlush, exStall;
    logic [3:0] idAluOp;
    logic [31:0] idRdata1, idRdata2, idImm, idPc, wbData;
    logic idexValid, idexRegWrite, idexMemRead, idexMemWrite, idexMemToReg, idexBranch, idStall;
    logic [4:0] idexRs1, idexRs2, idexRd;
    logic [3:0] idexAluOp;
    logic [31:0] idexRdata1, idexRdata2, idexImm, idexPc;
    logic [CW-1:0] bubbleCnt;

    int tests = 0;
    int failed = 0;

    idex_stage #(.XLEN(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idMemToReg(idMemToReg), .idBranch(idBranch), .idAluOp(idAluOp),
        .idRdata1(idRdata1), .idRdata2(idRdata2), .idImm(idImm), .idPc(idPc),
        .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
        .exFlush(exFlush), .exStall(exStall),
        .idexValid(idexValid), .idexRs1(idexRs1), .idexRs2(idexRs2), .idexRd(idexRd),
        .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead), .idexMemWrite(idexMemWrite),
        .idexMemToReg(idexMemToReg), .idexBranch(idexBranch), .idexAluOp(idexAluOp),
        .idexRdata1(idexRdata1), .idexRdata2(idexRdata2), .idexImm(idexImm), .idexPc(idexPc),
        .idStall(idStall), .bubbleCnt(bubbleCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic st_t dutState();
        st_t s;
        s = '{idexValid, idexRs1, idexRs2, idexRd, idexRegWrite, idexMemRead, idexMemWrite,
              idexMemToReg, idexBranch, idexAluOp, idexRdata1, idexRdata2, idexImm, idexPc, bubbleCnt};
        return s;
    endfunction

    task automatic clearIn();
        idValid = 0; idRs1 = 0; idRs2 = 0; idRd = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        idRegWrite = 0; idMemRead = 0; idMemWrite = 0; idMemToReg = 0; idBranch = 0;
        idAluOp = 0; idRdata1 = 0; idRdata2 = 0; idImm = 0; idPc = 0;
        wbRegWrite = 0; wbRd = 0; wbData = 0; exFlush = 0; exStall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearIn();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // ID holds "lw rd, 0(x1)"
    task automatic putLoad(input logic [4:0] rd);
        clearIn();
        idValid = 1; idRs1 = 1; idUsesRs1 = 1; idRd = rd; idRegWrite = 1;
        idMemRead = 1; idMemToReg = 1; idAluOp = 4'h0; idImm = 0; idPc = 32'h100;
        #1;
    endtask

    // ID holds "add rd, rs1, rs2"
    task automatic putAdd(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        clearIn();
        idValid = 1; idRs1 = rs1; idRs2 = rs2; idRd = rd; idUsesRs1 = 1; idUsesRs2 = 1;
        idRegWrite = 1; idAluOp = 4'h2; idRdata1 = 32'h11; idRdata2 = 32'h22; idPc = 32'h104;
        #1;
    endtask

    task automatic test_reset();
        st_t z = '0;
        rst_n = 1'b0;
        clearIn();
        #12;
        tests++;
        if (dutState() !== z || idStall !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got %h stall %b required all zero", dutState(), idStall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        putLoad(5); tick();
        putAdd(6, 5, 1);
        tests++;
        if (idStall !== 1'b1) begin failed++; $display("FAIL lu_stall: got %b required 1", idStall); end
        tick();
        tests++;
        if (idexValid !== 1'b0 || bubbleCnt !== 2'd1 || idexMemRead !== 1'b0 || idexRd !== 5'd0) begin
            failed++;
            $display("FAIL lu_bubble: got valid %b cnt %0d memRead %b rd %0d required 0 1 0 0",
                     idexValid, bubbleCnt, idexMemRead, idexRd);
        end
        tests++;
        if (idStall !== 1'b0) begin failed++; $display("FAIL lu_release: got %b required 0", idStall); end
        tick();
        tests++;
        if (idexValid !== 1'b1 || idexRs1 !== 5'd5 || idexRd !== 5'd6 || bubbleCnt !== 2'd1) begin
            failed++;
            $display("FAIL lu_capture: got valid %b rs1 %0d rd %0d cnt %0d required 1 5 6 1",
                     idexValid, idexRs1, idexRd, bubbleCnt);
        end
    endtask

    task automatic test_store_exempt();
        doReset();
        putLoad(5); tick();
        clearIn();
        idValid = 1; idRs1 = 2; idRs2 = 5; idUsesRs1 = 1; idUsesRs2 = 1; idMemWrite = 1;
        idAluOp = 4'h0; idPc = 32'h200; #1;
        tests++;
        if (idStall !== 1'b0) begin failed++; $display("FAIL store_stall: got %b required 0", idStall); end
        tick();
        tests++;
        if (idexValid !== 1'b1 || idexMemWrite !== 1'b1 || idexRs2 !== 5'd5 || idexPc !== 32'h200 || bubbleCnt !== 0) begin
            failed++;
            $display("FAIL store_capture: got valid %b memWrite %b rs2 %0d pc %h cnt %0d required 1 1 5 200 0",
                     idexValid, idexMemWrite, idexRs2, idexPc, bubbleCnt);
        end
        // Same load but the store's address (rs1) depends on it: must stall.
        putLoad(5); tick();
        clearIn();
        idValid = 1; idRs1 = 5; idRs2 = 3; idUsesRs1 = 1; idUsesRs2 = 1; idMemWrite = 1; #1;
        tests++;
        if (idStall !== 1'b1) begin failed++; $display("FAIL store_addr_stall: got %b required 1", idStall); end
    endtask

    task automatic test_x0_load();
        doReset();
        putLoad(0); tick();
        putAdd(6, 0, 0);
        tests++;
        if (idStall !== 1'b0) begin failed++; $display("FAIL x0_stall: got %b required 0", idStall); end
    endtask

    task automatic test_flush_priority();
        doReset();
        putLoad(5); tick();
        putAdd(6, 5, 1);
        exFlush = 1; #1;
        tests++;
        if (idStall !== 1'b0) begin failed++; $display("FAIL flush_stall: got %b required 0", idStall); end
        tick();
        tests++;
        if (idexValid !== 1'b0 || bubbleCnt !== 2'd0 || idexRegWrite !== 1'b0) begin
            failed++;
            $display("FAIL flush_bubble: got valid %b cnt %0d regWrite %b required 0 0 0",
                     idexValid, bubbleCnt, idexRegWrite);
        end
        // Stall and load-use together: hold, no count.
        putLoad(5); tick();
        putAdd(6, 5, 1);
        exStall = 1; #1;
        tests++;
        if (idStall !== 1'b1) begin failed++; $display("FAIL stall_lu_stall: got %b required 1", idStall); end
        tick();
        tests++;
        if (idexMemRead !== 1'b1 || idexRd !== 5'd5 || bubbleCnt !== 2'd0) begin
            failed++;
            $display("FAIL stall_lu_hold: got memRead %b rd %0d cnt %0d required 1 5 0", idexMemRead, idexRd, bubbleCnt);
        end
    endtask

    task automatic test_wb_bypass();
        doReset();
        putAdd(8, 3, 7);
        idRdata1 = 32'h1234; idRdata2 = 32'h0;
        wbRegWrite = 1; wbRd = 7; wbData = 32'hDEADBEEF; #1;
        tick();
        tests++;
        if (idexRdata2 !== 32'hDEADBEEF || idexRdata1 !== 32'h1234) begin
            failed++;
            $display("FAIL wb_bypass: got rdata1 %h rdata2 %h required 00001234 deadbeef", idexRdata1, idexRdata2);
        end
        // wbRd = 0 must not bypass.
        putAdd(8, 0, 0);
        idRdata1 = 32'h0; idRdata2 = 32'h0;
        wbRegWrite = 1; wbRd = 0; wbData = 32'hCAFEF00D; #1;
        tick();
        tests++;
        if (idexRdata1 !== 32'h0 || idexRdata2 !== 32'h0) begin
            failed++;
            $display("FAIL wb_bypass_x0: got rdata1 %h rdata2 %h required 0 0", idexRdata1, idexRdata2);
        end
    endtask

    task automatic test_hold();
        st_t snap;
        doReset();
        putAdd(9, 4, 5);
        idImm = 32'h55AA; tick();
        snap = dutState();
        for (int i = 0; i < 3; i++) begin
            clearIn();
            idValid = 1; idRs1 = 5'($urandom); idRd = 5'($urandom); idRdata1 = $urandom;
            idPc = $urandom; exStall = 1;
            wbRegWrite = 1; wbRd = 4; wbData = $urandom; #1;
            tests++;
            if (idStall !== 1'b1) begin failed++; $display("FAIL hold_stall: got %b required 1", idStall); end
            tick();
            tests++;
            if (dutState() !== snap) begin
                failed++;
                $display("FAIL hold_state: got %h required %h", dutState(), snap);
            end
        end
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < 5; i++) begin
            putLoad(5); tick();
            putAdd(6, 1, 5); tick();
        end
        tests++;
        if (bubbleCnt !== 2'd3) begin failed++; $display("FAIL saturation: got %0d required 3", bubbleCnt); end
    endtask

    task automatic test_async_reset();
        st_t z = '0;
        doReset();
        putLoad(5); tick();
        putAdd(6, 5, 1); tick();
        putAdd(7, 2, 3); tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dutState() !== z) begin
            failed++;
            $display("FAIL async_reset: got %h required all zero", dutState());
        end
        clearIn();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        st_t m, n;
        logic lu, expStall;
        doReset();
        m = '0;
        for (int c = 0; c < 400; c++) begin
            clearIn();
            idValid    = ($urandom_range(0, 9) != 0);
            idRs1      = 5'($urandom_range(0, 3));
            idRs2      = 5'($urandom_range(0, 3));
            idRd       = 5'($urandom_range(0, 3));
            idUsesRs1  = $urandom_range(0, 1);
            idUsesRs2  = $urandom_range(0, 1);
            idRegWrite = $urandom_range(0, 1);
            idMemRead  = ($urandom_range(0, 2) == 0);
            idMemWrite = ($urandom_range(0, 4) == 0);
            idMemToReg = $urandom_range(0, 1);
            idBranch   = $urandom_range(0, 1);
            idAluOp    = 4'($urandom);
            idRdata1   = $urandom; idRdata2 = $urandom; idImm = $urandom; idPc = $urandom;
            wbRegWrite = $urandom_range(0, 1);
            wbRd       = 5'($urandom_range(0, 3));
            wbData     = $urandom;
            exFlush    = ($urandom_range(0, 9) == 0);
            exStall    = ($urandom_range(0, 6) == 0);
            #1;
            // Model: does the instruction in ID need the load result sitting in EX?
            lu = idValid && m.valid && m.memRead && (m.rd != 0) &&
                 ((idUsesRs1 && idRs1 == m.rd) || (idUsesRs2 && idRs2 == m.rd && !idMemWrite));
            expStall = (lu || exStall) && !exFlush;
            tests++;
            if (idStall !== expStall) begin
                failed++;
                $display("FAIL rand_stall cyc %0d: got %b required %b", c, idStall, expStall);
            end
            n = '0;
            n.cnt = m.cnt;
            if (exFlush) begin
            end else if (exStall) begin
                n = m;
            end else if (lu) begin
                n.cnt = (m.cnt == 2'd3) ? 2'd3 : m.cnt + 2'd1;
            end else if (idValid) begin
                n = '{1'b1, idRs1, idRs2, idRd, idRegWrite, idMemRead, idMemWrite, idMemToReg,
                      idBranch, idAluOp,
                      (wbRegWrite && wbRd != 0 && wbRd == idRs1) ? wbData : idRdata1,
                      (wbRegWrite && wbRd != 0 && wbRd == idRs2) ? wbData : idRdata2,
                      idImm, idPc, m.cnt};
            end
            tick();
            m = n;
            tests++;
            if (dutState() !== m) begin
                failed++;
                $display("FAIL rand_state cyc %0d: got %h required %h", c, dutState(), m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_exempt();
        test_x0_load();
        test_flush_priority();
        test_wb_bypass();
        test_hold();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline stage of the RV32I 5-stage core: registers decoded instruction state from ID into EX and produces the `idexRs1/idexRs2` fields the forwarding unit compares against EX/MEM and MEM/WB destinations. It detects load-use hazards the forwarding paths cannot cover and inserts a bubble. It kills its contents on a taken branch or jump and bypasses same-cycle register-file writeback into the captured operands. A saturating counter records inserted bubbles for performance monitoring.

## Interface
- `XLEN`, 32, datapath width
- `CNT_WIDTH`, 16, bubble counter width
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `idValid`  in  1  ID holds a valid instruction
- `idRs1`, `idRs2`, `idRd`  in  `RF_ADDR_WIDTH` each  decoded register addresses
- `idUsesRs1`, `idUsesRs2`  in  1 each  the instruction actually reads rs1/rs2
- `idRegWrite`, `idMemRead`, `idMemWrite`, `idMemToReg`, `idBranch`  in  1 each  decoded control
- `idAluOp`  in  `ALU_OP_WIDTH`  ALU operation
- `idRdata1`, `idRdata2`, `idImm`, `idPc`  in  `XLEN` each  register-file reads, immediate, PC
- `wbRegWrite`  in  1  WB writes the register file this cycle
- `wbRd`  in  `RF_ADDR_WIDTH`  WB destination
- `wbData`  in  `XLEN`  WB data
- `exFlush`  in  1  taken branch/jump resolved in EX
- `exStall`  in  1  downstream hold request
- `idexValid`, `idexRs1`, `idexRs2`, `idexRd`, `idexRegWrite`, `idexMemRead`, `idexMemWrite`, `idexMemToReg`, `idexBranch`, `idexAluOp`, `idexRdata1`, `idexRdata2`, `idexImm`, `idexPc`  out  widths as matching inputs  registered EX-stage state
- `idStall`  out  1  freeze PC and IF/ID (combinational)
- `bubbleCnt`  out  `CNT_WIDTH`  saturating count of load-use bubbles

## Operation
- **Load-use hazard** (`loadUse`) is asserted when all of the following hold:
  - `idValid & idexValid & idexMemRead & idexRd != 0`.
  - Either `idUsesRs1 & idRs1 == idexRd`, or `idUsesRs2 & idRs2 == idexRd & !idMemWrite`.
  - A store whose rs2 depends on the load does not stall. That value is forwarded at MEM.
- `idStall = (loadUse | exStall) & !exFlush`.
- **Register update priority** each clock edge, highest first:
  1. **exFlush**: load a bubble.
  2. **exStall**: hold all registers.
  3. **loadUse**: load a bubble and increment `bubbleCnt`.
  4. **Otherwise**: capture ID. `idexValid` is set to `idValid`.
- **Bubble**:
  - `idexValid`, all control bits, `idexRs1/Rs2/Rd` and `idexAluOp` are set to 0.
  - Data fields are set to 0.
- **Capture with `idValid` = 0** is treated as a bubble, but does not count toward `bubbleCnt`.
- **WB bypass on capture**:
  - If `wbRegWrite & wbRd != 0 & wbRd == idRs1`, capture `wbData` into `idexRdata1`. The same rule applies to rs2 and `idexRdata2`.
  - There is no bypass while holding.
- **`bubbleCnt`**:
  - Increments by 1 per load-use bubble and saturates at all-ones.
  - It is not affected by `exFlush` bubbles.

## Timing
- Reset values: every registered output is 0, including `bubbleCnt` and `idexValid`. Reset is asynchronous; deassertion is synchronous to `clk` upstream of this block.
- Reset mid-operation discards the in-flight instruction immediately. There is no partial state.
- Latency: 1 cycle from ID inputs to `idex*` outputs.
- `idStall` is purely combinational from the current `idex*` registers and ID inputs. It is valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, `idexMemRead` is 0, so `loadUse` deasserts and the instruction proceeds next cycle with fwu forwarding from MEM/WB.
- When `exFlush` and `loadUse` coincide, the flush wins: `idStall` = 0 and the counter is unchanged.
- When `exStall` and `loadUse` coincide, the stage holds: `idStall` = 1 and the counter is unchanged.

## Structure
- Shared package `rv32i_defs`:
  - Holds `RF_ADDR_WIDTH`, `ALU_OP_WIDTH`, `XLEN`.
  - Holds a new `idex_ctrl_t` packed struct containing regWrite, memRead, memWrite, memToReg, branch and aluOp, so bubbles zero one field.
- One sub-module, `haz_detect`: combinational `loadUse` computation. The registers, bypass and counter stay in `idex_stage`.

## Test plan
- **Load-use stall**: EX holds `lw x5` (`idexMemRead`=1, `idexRd`=5); ID holds `add x6,x5,x1` with `idUsesRs1`=1.
  - Required: `idStall`=1 that cycle.
  - Next edge: `idexValid`=0 and `bubbleCnt`=1.
  - Following edge: the add is captured with `idexRs1`=5.
- **Store exemption**: EX holds `lw x5`; ID holds `sw x5,0(x2)` (`idRs2`=5, `idMemWrite`=1).
  - Required: `idStall`=0 and the store is captured next edge.
- **x0 load**: EX holds `lw x0`; ID reads x0.
  - Required: no stall.
- **Flush priority**: `exFlush`=1 with `loadUse`=1.
  - Required: `idStall`=0, next-edge `idexValid`=0, `bubbleCnt` unchanged.
- **WB bypass**: `wbRegWrite`=1, `wbRd`=7, `wbData`=0xDEADBEEF, `idRs2`=7, `idRdata2`=0.
  - Required: `idexRdata2`=0xDEADBEEF after the edge.
- **Hold, saturation and reset**:
  - `exStall`=1 for 3 cycles: outputs are unchanged.
  - With `CNT_WIDTH`=2, force 5 load-use bubbles: `bubbleCnt` reads 3.
  - Assert `rst_n`=0 mid-sequence: all outputs read 0 immediately, without a clock edge.
